effect_chain_scheduler: RTL and testbench
=========================================

Name: effect_chain_scheduler

Overview:
- Sequences the audio effect chain once per incoming sample.
- Grants `my_turn` to each enabled effect in fixed order and chains each effect's `data_out` into the next effect's `data_in`.
- Arbitrates the single smart_ram port so only the effect holding the turn can access it.
- Owns the circular delay-line write pointer. Effects supply only a relative `sram_offset`; this block converts it to an absolute address.

Parameters:
- DATA_WIDTH, 16, sample width (signed two's complement).
- ADDR_WIDTH, 12, width of per-effect relative offset and of each effect's RAM region.
- NUM_EFFECTS, 4, number of effect slots; index 0 runs first.
- IDX_W, 2, clog2(NUM_EFFECTS).
- TIMEOUT, 1023, maximum cycles an effect may hold the turn.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sample_valid  in  1  one-cycle pulse, new sample present
- sample_in  in  DATA_WIDTH  input sample
- sample_out  out  DATA_WIDTH  processed sample
- sample_out_valid  out  1  one-cycle pulse
- fx_enable  in  NUM_EFFECTS  per-slot enable; sampled at sample_valid
- freeze  in  1  1 = suppress delay-line writes (should_save low)
- fx_cs  out  NUM_EFFECTS  registered copy of latched fx_enable
- fx_my_turn  out  NUM_EFFECTS  one-hot turn grant
- fx_should_save  out  1  equals the inverse of freeze latched at sample_valid
- fx_data_in  out  DATA_WIDTH  current chain value, broadcast to all slots
- fx_data_out  in  NUM_EFFECTS*DATA_WIDTH  per-slot result, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
- fx_done  in  NUM_EFFECTS  per-slot done pulse
- fx_available  in  NUM_EFFECTS  per-slot idle flag
- fx_sram_rd, fx_sram_wr  in  NUM_EFFECTS  per-slot strobes
- fx_sram_offset  in  NUM_EFFECTS*ADDR_WIDTH  per-slot relative offset
- fx_sram_data  in  NUM_EFFECTS*DATA_WIDTH  per-slot write data
- fx_read_finish, fx_write_finish  out  NUM_EFFECTS  finish pulses, routed to the granted slot only
- ram_rd, ram_wr  out  1  registered strobes to smart_ram
- ram_addr  out  ADDR_WIDTH+IDX_W  absolute address, equal to {idx, rel}
- ram_wdata  out  DATA_WIDTH  write data
- ram_read_finish, ram_write_finish  in  1  from smart_ram
- overrun, timeout_err  out  1  sticky error flags

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - state = IDLE, idx = 0, wr_ptr = 0, chain = 0.
  - All outputs are 0.
  - Reset mid-operation abandons the sample; ram_rd and ram_wr are low in the next cycle.
- States: IDLE, GRANT, WAIT_DONE, OUTPUT.
- IDLE:
  - On sample_valid: chain <= sample_in; latch fx_enable and !freeze; idx <= 0; go to GRANT.
- GRANT:
  - Slot disabled: idx++ (chain unchanged). If idx == NUM_EFFECTS-1, go to OUTPUT.
  - Slot enabled and fx_available[idx] = 1: fx_my_turn <= one-hot(idx); clear the timer; go to WAIT_DONE.
  - Slot enabled and not available: stay in GRANT and count the timer.
- WAIT_DONE:
  - On fx_done[idx]: chain <= fx_data_out slot idx; fx_my_turn <= 0; advance as in GRANT (next slot, or OUTPUT after the last).
  - When the timer reaches TIMEOUT (in GRANT or WAIT_DONE): bypass the slot with chain unchanged; set timeout_err; drop the turn.
- OUTPUT:
  - sample_out <= chain; sample_out_valid = 1 for exactly 1 cycle.
  - wr_ptr <= wr_ptr + 2 (addresses are even), wrapping mod 2^ADDR_WIDTH.
  - Go to IDLE.
- Latency with all slots disabled: sample_out_valid rises after edge NUM_EFFECTS+1, counting the edge that samples sample_valid as edge 0.
- sample_valid outside IDLE: the sample is dropped and overrun is set (sticky until rst).
- RAM arbitration:
  - Only strobes from the slot with fx_my_turn set are forwarded; others are ignored.
  - ram_rd, ram_wr, ram_addr and ram_wdata are registered, giving 1 cycle latency from a client strobe.
  - Address: rel = (wr_ptr - offset) mod 2^ADDR_WIDTH, so offset 0 is the current sample slot.
  - rd and wr asserted in the same cycle: rd wins; wr is dropped and timeout_err is not set.
  - ram_read_finish and ram_write_finish are forwarded combinationally to the granted slot's finish bit only.
  - A finish arriving with no grant is discarded.
- fx_data_in = chain, updated only on state transitions.

Decomposition:
- Package audio_fx_pkg holds:
  - the state enum;
  - the DATA_WIDTH and ADDR_WIDTH defaults;
  - the address composition helper (idx, wr_ptr, offset → ram_addr).
- Sub-module sram_port_mux holds the grant-gated request mux, the address arithmetic, the output registers and the finish demux.

Test Plan:
- All slots disabled, sample_valid with sample_in = 16'h1234 → sample_out = 16'h1234; sample_out_valid after edge 5 for NUM_EFFECTS = 4; wr_ptr goes 0 → 2.
- Slot 1 only enabled; its model returns sample + 1 with done 3 cycles after the turn → sample_out = 16'h1235; fx_my_turn = 4'b0010 only while waiting.
- Slot 2 requests rd with offset 4 at wr_ptr = 2 → ram_addr = {2'd2, 12'hFFE}, ram_rd high one cycle later; read_finish reaches fx_read_finish[2] only.
- Slot 0 never asserts done → after TIMEOUT cycles the slot is bypassed, timeout_err = 1, and the chain value passes through unchanged.
- sample_valid while in WAIT_DONE → overrun = 1; the in-flight sample completes correctly.
- rst asserted in WAIT_DONE with ram_rd high → next cycle all outputs are 0; the next sample processes normally.

Source files
------------

// File: rtl/audio_fx_pkg.sv
// Shared types, default widths and the RAM address helper for the effect chain.
// Contents:
//   fsm_state_e  - scheduler state encoding
//   ram_req_t    - registered request presented to smart_ram
//   compose_addr - converts a slot index, write pointer and relative offset
//                  into an absolute smart_ram address {idx, wr_ptr - offset}
package audio_fx_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 16;
  localparam int unsigned DEF_ADDR_WIDTH  = 12;
  localparam int unsigned DEF_NUM_EFFECTS = 4;
  localparam int unsigned DEF_IDX_W       = 2;
  localparam int unsigned DEF_TIMEOUT     = 1023;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_OUTPUT    = 2'd3
  } fsm_state_e;

  typedef struct packed {
    logic                                rd;
    logic                                wr;
    logic [DEF_IDX_W+DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0]           wdata;
  } ram_req_t;

  // Each slot owns a 2^ADDR_WIDTH region; offset 0 addresses the newest sample.
  function automatic logic [DEF_IDX_W+DEF_ADDR_WIDTH-1:0] compose_addr(
    input logic [DEF_IDX_W-1:0]      idx,
    input logic [DEF_ADDR_WIDTH-1:0] wr_ptr,
    input logic [DEF_ADDR_WIDTH-1:0] offset
  );
    logic [DEF_ADDR_WIDTH-1:0] rel;
    rel = wr_ptr - offset;
    return {idx, rel};
  endfunction

endpackage

// File: rtl/sram_port_mux.sv
// Grant-gated access to the single smart_ram port.
// Ports:
//   i_clk, i_rst         - clock, synchronous active-high reset
//   i_turn, i_idx        - one-hot grant and index of the slot holding the turn
//   i_wr_ptr             - circular delay-line write pointer
//   i_fx_sram_*          - per-slot strobes, relative offsets, write data
//   o_ram_*              - registered request to smart_ram (1 cycle latency)
//   i_ram_*_finish       - completion pulses from smart_ram
//   o_fx_*_finish        - completion pulses routed to the granted slot only
module sram_port_mux
  import audio_fx_pkg::*;
#(
  parameter int unsigned NUM_EFFECTS = DEF_NUM_EFFECTS
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic [NUM_EFFECTS-1:0]                  i_turn,
  input  logic [DEF_IDX_W-1:0]                    i_idx,
  input  logic [DEF_ADDR_WIDTH-1:0]               i_wr_ptr,
  input  logic [NUM_EFFECTS-1:0]                  i_fx_sram_rd,
  input  logic [NUM_EFFECTS-1:0]                  i_fx_sram_wr,
  input  logic [NUM_EFFECTS*DEF_ADDR_WIDTH-1:0]   i_fx_sram_offset,
  input  logic [NUM_EFFECTS*DEF_DATA_WIDTH-1:0]   i_fx_sram_data,
  input  logic                                    i_ram_read_finish,
  input  logic                                    i_ram_write_finish,
  output logic                                    o_ram_rd,
  output logic                                    o_ram_wr,
  output logic [DEF_IDX_W+DEF_ADDR_WIDTH-1:0]     o_ram_addr,
  output logic [DEF_DATA_WIDTH-1:0]               o_ram_wdata,
  output logic [NUM_EFFECTS-1:0]                  o_fx_read_finish,
  output logic [NUM_EFFECTS-1:0]                  o_fx_write_finish
);

  localparam int unsigned DW = DEF_DATA_WIDTH;
  localparam int unsigned AW = DEF_ADDR_WIDTH;

  logic          w_rd;
  logic          w_wr;
  logic [AW-1:0] w_offset;
  logic [DW-1:0] w_wdata;
  ram_req_t      r_req;

  // Only the slot holding the turn reaches the RAM; a read beats a write.
  assign w_rd     = i_turn[i_idx] & i_fx_sram_rd[i_idx];
  assign w_wr     = i_turn[i_idx] & i_fx_sram_wr[i_idx] & ~w_rd;
  assign w_offset = i_fx_sram_offset[i_idx*AW +: AW];
  assign w_wdata  = i_fx_sram_data[i_idx*DW +: DW];

  // Request register; address and data hold between accepted strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req <= '0;
    end else begin
      r_req.rd <= w_rd;
      r_req.wr <= w_wr;
      if (w_rd | w_wr) r_req.addr <= compose_addr(i_idx, i_wr_ptr, w_offset);
      if (w_wr) r_req.wdata <= w_wdata;
    end
  end

  assign o_ram_rd    = r_req.rd;
  assign o_ram_wr    = r_req.wr;
  assign o_ram_addr  = r_req.addr;
  assign o_ram_wdata = r_req.wdata;

  // Finish demux: with no grant the turn vector is zero and the pulse is lost.
  assign o_fx_read_finish  = i_turn & {NUM_EFFECTS{i_ram_read_finish}};
  assign o_fx_write_finish = i_turn & {NUM_EFFECTS{i_ram_write_finish}};

endmodule

// File: rtl/effect_chain_scheduler.sv
// Runs the enabled effect slots in order once per input sample, chaining each
// slot's result into the next, and owns the delay-line write pointer.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   sample_valid/sample_in         - new input sample
//   sample_out/sample_out_valid    - processed sample, one-cycle valid
//   fx_enable, freeze              - per-slot enables and save suppression
//   fx_cs, fx_my_turn, fx_should_save, fx_data_in - slot control broadcast
//   fx_data_out, fx_done, fx_available            - slot results/status
//   fx_sram_*, fx_*_finish, ram_*  - shared smart_ram port (see sram_port_mux)
//   overrun, timeout_err           - sticky error flags
module effect_chain_scheduler
  import audio_fx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_EFFECTS = DEF_NUM_EFFECTS,
  parameter int unsigned IDX_W       = DEF_IDX_W,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sample_valid,
  input  logic [DATA_WIDTH-1:0]             sample_in,
  output logic [DATA_WIDTH-1:0]             sample_out,
  output logic                              sample_out_valid,
  input  logic [NUM_EFFECTS-1:0]            fx_enable,
  input  logic                              freeze,
  output logic [NUM_EFFECTS-1:0]            fx_cs,
  output logic [NUM_EFFECTS-1:0]            fx_my_turn,
  output logic                              fx_should_save,
  output logic [DATA_WIDTH-1:0]             fx_data_in,
  input  logic [NUM_EFFECTS*DATA_WIDTH-1:0] fx_data_out,
  input  logic [NUM_EFFECTS-1:0]            fx_done,
  input  logic [NUM_EFFECTS-1:0]            fx_available,
  input  logic [NUM_EFFECTS-1:0]            fx_sram_rd,
  input  logic [NUM_EFFECTS-1:0]            fx_sram_wr,
  input  logic [NUM_EFFECTS*ADDR_WIDTH-1:0] fx_sram_offset,
  input  logic [NUM_EFFECTS*DATA_WIDTH-1:0] fx_sram_data,
  output logic [NUM_EFFECTS-1:0]            fx_read_finish,
  output logic [NUM_EFFECTS-1:0]            fx_write_finish,
  output logic                              ram_rd,
  output logic                              ram_wr,
  output logic [ADDR_WIDTH+IDX_W-1:0]       ram_addr,
  output logic [DATA_WIDTH-1:0]             ram_wdata,
  input  logic                              ram_read_finish,
  input  logic                              ram_write_finish,
  output logic                              overrun,
  output logic                              timeout_err
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  fsm_state_e              r_state,   w_state_nxt;
  logic [IDX_W-1:0]        r_idx,     w_idx_nxt;
  logic [DATA_WIDTH-1:0]   r_chain,   w_chain_nxt;
  logic [NUM_EFFECTS-1:0]  r_en,      w_en_nxt;
  logic                    r_save,    w_save_nxt;
  logic [NUM_EFFECTS-1:0]  r_turn,    w_turn_nxt;
  logic [TMR_W-1:0]        r_timer,   w_timer_nxt;
  logic [DATA_WIDTH-1:0]   r_out,     w_out_nxt;
  logic                    r_out_vld, w_out_vld_nxt;
  logic [ADDR_WIDTH-1:0]   r_wr_ptr,  w_wr_ptr_nxt;
  logic                    r_overrun, w_overrun_nxt;
  logic                    r_tmo,     w_tmo_nxt;
  logic                    w_advance;
  logic                    w_timer_exp;

  assign w_timer_exp = (r_timer == TMR_W'(TIMEOUT));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_chain   <= '0;
      r_en      <= '0;
      r_save    <= 1'b0;
      r_turn    <= '0;
      r_timer   <= '0;
      r_out     <= '0;
      r_out_vld <= 1'b0;
      r_wr_ptr  <= '0;
      r_overrun <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_chain   <= w_chain_nxt;
      r_en      <= w_en_nxt;
      r_save    <= w_save_nxt;
      r_turn    <= w_turn_nxt;
      r_timer   <= w_timer_nxt;
      r_out     <= w_out_nxt;
      r_out_vld <= w_out_vld_nxt;
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_overrun <= w_overrun_nxt;
      r_tmo     <= w_tmo_nxt;
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_chain_nxt   = r_chain;
    w_en_nxt      = r_en;
    w_save_nxt    = r_save;
    w_turn_nxt    = r_turn;
    w_timer_nxt   = r_timer;
    w_out_nxt     = r_out;
    w_out_vld_nxt = 1'b0;
    w_wr_ptr_nxt  = r_wr_ptr;
    w_tmo_nxt     = r_tmo;
    w_advance     = 1'b0;
    // A sample arriving while the chain is busy is dropped.
    w_overrun_nxt = r_overrun | (sample_valid & (r_state != ST_IDLE));

    case (r_state)
      ST_IDLE: begin
        if (sample_valid) begin
          w_chain_nxt = sample_in;
          w_en_nxt    = fx_enable;
          w_save_nxt  = ~freeze;
          w_idx_nxt   = '0;
          w_timer_nxt = '0;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!r_en[r_idx]) begin
          w_advance = 1'b1;
        end else if (fx_available[r_idx]) begin
          w_turn_nxt  = NUM_EFFECTS'(1) << r_idx;
          w_timer_nxt = '0;
          w_state_nxt = ST_WAIT_DONE;
        end else if (w_timer_exp) begin
          w_tmo_nxt = 1'b1;
          w_advance = 1'b1;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (fx_done[r_idx]) begin
          w_chain_nxt = fx_data_out[r_idx*DATA_WIDTH +: DATA_WIDTH];
          w_turn_nxt  = '0;
          w_advance   = 1'b1;
        end else if (w_timer_exp) begin
          // Bypass a hung slot: chain value passes through untouched.
          w_tmo_nxt  = 1'b1;
          w_turn_nxt = '0;
          w_advance  = 1'b1;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      ST_OUTPUT: begin
        w_out_nxt     = r_chain;
        w_out_vld_nxt = 1'b1;
        // Two addresses per sample keep delay-line addresses even.
        w_wr_ptr_nxt  = r_wr_ptr + ADDR_WIDTH'(2);
        w_state_nxt   = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_advance) begin
      w_timer_nxt = '0;
      w_idx_nxt   = r_idx + IDX_W'(1);
      w_state_nxt = (r_idx == IDX_W'(NUM_EFFECTS - 1)) ? ST_OUTPUT : ST_GRANT;
    end
  end

  sram_port_mux #(
    .NUM_EFFECTS(NUM_EFFECTS)
  ) u_sram_port_mux (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_turn             (r_turn),
    .i_idx              (r_idx),
    .i_wr_ptr           (r_wr_ptr),
    .i_fx_sram_rd       (fx_sram_rd),
    .i_fx_sram_wr       (fx_sram_wr),
    .i_fx_sram_offset   (fx_sram_offset),
    .i_fx_sram_data     (fx_sram_data),
    .i_ram_read_finish  (ram_read_finish),
    .i_ram_write_finish (ram_write_finish),
    .o_ram_rd           (ram_rd),
    .o_ram_wr           (ram_wr),
    .o_ram_addr         (ram_addr),
    .o_ram_wdata        (ram_wdata),
    .o_fx_read_finish   (fx_read_finish),
    .o_fx_write_finish  (fx_write_finish)
  );

  assign sample_out       = r_out;
  assign sample_out_valid = r_out_vld;
  assign fx_cs            = r_en;
  assign fx_my_turn       = r_turn;
  assign fx_should_save   = r_save;
  assign fx_data_in       = r_chain;
  assign overrun          = r_overrun;
  assign timeout_err      = r_tmo;

endmodule

// File: tb/tb_effect_chain_scheduler.sv
// Self-checking bench for effect_chain_scheduler with a scoreboard of expected
// output samples and a small per-slot effect model (result = data_in + m_add).
module tb_effect_chain_scheduler;

  localparam int DW  = 16;
  localparam int AW  = 12;
  localparam int NFX = 4;
  localparam int IW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              sample_valid;
  logic [DW-1:0]     sample_in;
  logic [DW-1:0]     sample_out;
  logic              sample_out_valid;
  logic [NFX-1:0]    fx_enable;
  logic              freeze;
  logic [NFX-1:0]    fx_cs;
  logic [NFX-1:0]    fx_my_turn;
  logic              fx_should_save;
  logic [DW-1:0]     fx_data_in;
  logic [NFX*DW-1:0] fx_data_out;
  logic [NFX-1:0]    fx_done;
  logic [NFX-1:0]    fx_available;
  logic [NFX-1:0]    fx_sram_rd;
  logic [NFX-1:0]    fx_sram_wr;
  logic [NFX*AW-1:0] fx_sram_offset;
  logic [NFX*DW-1:0] fx_sram_data;
  logic [NFX-1:0]    fx_read_finish;
  logic [NFX-1:0]    fx_write_finish;
  logic              ram_rd;
  logic              ram_wr;
  logic [AW+IW-1:0]  ram_addr;
  logic [DW-1:0]     ram_wdata;
  logic              ram_read_finish;
  logic              ram_write_finish;
  logic              overrun;
  logic              timeout_err;

  effect_chain_scheduler dut (
    .clk(clk), .rst(rst),
    .sample_valid(sample_valid), .sample_in(sample_in),
    .sample_out(sample_out), .sample_out_valid(sample_out_valid),
    .fx_enable(fx_enable), .freeze(freeze),
    .fx_cs(fx_cs), .fx_my_turn(fx_my_turn), .fx_should_save(fx_should_save),
    .fx_data_in(fx_data_in), .fx_data_out(fx_data_out),
    .fx_done(fx_done), .fx_available(fx_available),
    .fx_sram_rd(fx_sram_rd), .fx_sram_wr(fx_sram_wr),
    .fx_sram_offset(fx_sram_offset), .fx_sram_data(fx_sram_data),
    .fx_read_finish(fx_read_finish), .fx_write_finish(fx_write_finish),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_read_finish(ram_read_finish), .ram_write_finish(ram_write_finish),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0]  sb[$];
  logic [AW-1:0]  exp_wr_ptr;
  logic [NFX-1:0] m_auto;
  int             m_cnt[NFX];
  int             m_delay;
  logic [DW-1:0]  m_add;

  // Effect model for slots under automatic control: done m_delay+1 cycles after turn.
  task automatic model_step();
    for (int i = 0; i < NFX; i++) begin
      if (m_auto[i]) begin
        fx_done[i] = 1'b0;
        if (fx_my_turn[i]) begin
          if (m_cnt[i] == m_delay) begin
            fx_done[i] = 1'b1;
            fx_data_out[i*DW +: DW] = fx_data_in + m_add;
            m_cnt[i] = 0;
          end else begin
            m_cnt[i]++;
          end
        end else begin
          m_cnt[i] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic collect(input int budget, output int cycles, output bit got);
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < budget) begin
      tick();
      cycles++;
      if (sample_out_valid) got = 1'b1;
    end
  endtask

  task automatic wait_turn(input int budget, output bit got);
    got = 1'b0;
    for (int n = 0; n < budget && !got; n++) begin
      if (fx_my_turn != '0) got = 1'b1;
      else tick();
    end
  endtask

  task automatic send(input logic [DW-1:0] s);
    sample_in = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [127:0] all_out;
    rst = 1'b1;
    tick();
    tick();
    all_out = 128'({sample_out, sample_out_valid, fx_cs, fx_my_turn, fx_should_save,
                    fx_data_in, fx_read_finish, fx_write_finish, ram_rd, ram_wr,
                    ram_addr, ram_wdata, overrun, timeout_err});
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    rst = 1'b0;
    exp_wr_ptr = '0;
  endtask

  task automatic test_all_disabled();
    int cyc; bit got; logic [DW-1:0] exp;
    fx_enable = 4'b0000;
    freeze = 1'b0;
    sb.push_back(16'h1234);
    send(16'h1234);
    checks++;
    if (fx_should_save !== 1'b1 || fx_cs !== 4'b0000) begin
      failures++;
      $display("FAIL latch_ctrl got save=%b cs=%b exp save=1 cs=0000", fx_should_save, fx_cs);
    end
    collect(20, cyc, got);
    exp = sb.pop_front();
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL disabled_timeout got=no_output exp=output");
    end else if (sample_out !== exp) begin
      failures++;
      $display("FAIL disabled_value got=%h exp=%h", sample_out, exp);
    end
    checks++;
    if (cyc != NFX + 1) begin
      failures++;
      $display("FAIL disabled_latency got=%0d exp=%0d", cyc, NFX + 1);
    end
    exp_wr_ptr = exp_wr_ptr + 12'd2;
    tick();
    checks++;
    if (sample_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL valid_pulse got=%b exp=0", sample_out_valid);
    end
  endtask

  task automatic test_ram_arb();
    int cyc; bit got; logic [DW-1:0] exp; logic [AW-1:0] rel; logic [AW+IW-1:0] exp_addr;
    fx_enable = 4'b0100;
    m_auto[2] = 1'b0;
    sb.push_back(16'h4321);
    send(16'h4000);
    wait_turn(20, got);
    checks++;
    if (fx_my_turn !== 4'b0100) begin
      failures++;
      $display("FAIL ram_turn got=%b exp=0100", fx_my_turn);
    end
    // Request from a non-granted slot must be ignored.
    fx_sram_rd = 4'b0001;
    tick();
    checks++;
    if (ram_rd !== 1'b0) begin
      failures++;
      $display("FAIL ungranted_rd got=%b exp=0", ram_rd);
    end
    fx_sram_offset = '0;
    fx_sram_offset[2*AW +: AW] = 12'd4;
    fx_sram_offset[0 +: AW] = 12'h055;
    fx_sram_rd = 4'b0101;
    tick();
    fx_sram_rd = '0;
    rel = exp_wr_ptr - 12'd4;
    exp_addr = {2'd2, rel};
    checks++;
    if (ram_rd !== 1'b1 || ram_wr !== 1'b0 || ram_addr !== exp_addr) begin
      failures++;
      $display("FAIL rd_req got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=%h", ram_rd, ram_wr, ram_addr, exp_addr);
    end
    tick();
    checks++;
    if (ram_rd !== 1'b0) begin
      failures++;
      $display("FAIL rd_one_cycle got=%b exp=0", ram_rd);
    end
    ram_read_finish = 1'b1;
    #1;
    checks++;
    if (fx_read_finish !== 4'b0100 || fx_write_finish !== 4'b0000) begin
      failures++;
      $display("FAIL rd_finish got rf=%b wf=%b exp rf=0100 wf=0000", fx_read_finish, fx_write_finish);
    end
    ram_read_finish = 1'b0;
    ram_write_finish = 1'b1;
    #1;
    checks++;
    if (fx_write_finish !== 4'b0100) begin
      failures++;
      $display("FAIL wr_finish got=%b exp=0100", fx_write_finish);
    end
    ram_write_finish = 1'b0;
    // Simultaneous rd and wr: read wins, no error.
    fx_sram_offset[2*AW +: AW] = 12'd0;
    fx_sram_rd[2] = 1'b1;
    fx_sram_wr[2] = 1'b1;
    tick();
    fx_sram_rd = '0;
    fx_sram_wr = '0;
    checks++;
    if ({ram_rd, ram_wr} !== 2'b10 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL rd_wins got rd=%b wr=%b tmo=%b exp rd=1 wr=0 tmo=0", ram_rd, ram_wr, timeout_err);
    end
    fx_sram_offset[2*AW +: AW] = 12'd1;
    fx_sram_data[2*DW +: DW] = 16'hA5A5;
    fx_sram_wr[2] = 1'b1;
    tick();
    fx_sram_wr = '0;
    rel = exp_wr_ptr - 12'd1;
    exp_addr = {2'd2, rel};
    checks++;
    if ({ram_rd, ram_wr} !== 2'b01 || ram_wdata !== 16'hA5A5 || ram_addr !== exp_addr) begin
      failures++;
      $display("FAIL wr_req got rw=%b%b data=%h addr=%h exp rw=01 data=a5a5 addr=%h", ram_rd, ram_wr, ram_wdata, ram_addr, exp_addr);
    end
    fx_data_out[2*DW +: DW] = 16'h4321;
    fx_done[2] = 1'b1;
    tick();
    fx_done[2] = 1'b0;
    collect(20, cyc, got);
    exp = sb.pop_front();
    checks++;
    if (!got || sample_out !== exp) begin
      failures++;
      $display("FAIL ram_chain_out got=%h valid_seen=%b exp=%h", sample_out, got, exp);
    end
    exp_wr_ptr = exp_wr_ptr + 12'd2;
    m_auto[2] = 1'b1;
    ram_read_finish = 1'b1;
    #1;
    checks++;
    if (fx_read_finish !== 4'b0000) begin
      failures++;
      $display("FAIL finish_no_grant got=%b exp=0000", fx_read_finish);
    end
    ram_read_finish = 1'b0;
  endtask

  task automatic test_slot1();
    int cyc; bit got; logic [DW-1:0] exp;
    fx_enable = 4'b0010;
    freeze = 1'b1;
    m_delay = 3;
    m_add = 16'd1;
    sb.push_back(16'h1235);
    send(16'h1234);
    checks++;
    if (fx_should_save !== 1'b0 || fx_cs !== 4'b0010) begin
      failures++;
      $display("FAIL slot1_ctrl got save=%b cs=%b exp save=0 cs=0010", fx_should_save, fx_cs);
    end
    wait_turn(20, got);
    checks++;
    if (fx_my_turn !== 4'b0010) begin
      failures++;
      $display("FAIL slot1_turn got=%b exp=0010", fx_my_turn);
    end
    collect(30, cyc, got);
    exp = sb.pop_front();
    checks++;
    if (!got || sample_out !== exp) begin
      failures++;
      $display("FAIL slot1_out got=%h valid_seen=%b exp=%h", sample_out, got, exp);
    end
    checks++;
    if (fx_my_turn !== 4'b0000) begin
      failures++;
      $display("FAIL slot1_turn_drop got=%b exp=0000", fx_my_turn);
    end
    exp_wr_ptr = exp_wr_ptr + 12'd2;
    freeze = 1'b0;
  endtask

  task automatic test_timeout();
    int cyc; bit got; logic [DW-1:0] exp;
    fx_enable = 4'b0001;
    m_auto[0] = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_pre got=%b exp=0", timeout_err);
    end
    sb.push_back(16'hBEEF);
    send(16'hBEEF);
    collect(1200, cyc, got);
    exp = sb.pop_front();
    checks++;
    if (!got || sample_out !== exp) begin
      failures++;
      $display("FAIL tmo_bypass got=%h valid_seen=%b exp=%h", sample_out, got, exp);
    end
    checks++;
    if (timeout_err !== 1'b1 || fx_my_turn !== 4'b0000) begin
      failures++;
      $display("FAIL tmo_flag got tmo=%b turn=%b exp tmo=1 turn=0000", timeout_err, fx_my_turn);
    end
    checks++;
    if (cyc < 1023 || cyc > 1023 + NFX + 10) begin
      failures++;
      $display("FAIL tmo_window got=%0d exp=1023..%0d", cyc, 1023 + NFX + 10);
    end
    exp_wr_ptr = exp_wr_ptr + 12'd2;
    m_auto[0] = 1'b1;
  endtask

  task automatic test_overrun();
    int cyc; bit got; int extra; logic [DW-1:0] exp;
    fx_enable = 4'b0010;
    m_add = 16'd1;
    sb.push_back(16'h0101);
    send(16'h0100);
    wait_turn(20, got);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_pre got=%b exp=0", overrun);
    end
    send(16'h7777);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set got=%b exp=1", overrun);
    end
    collect(30, cyc, got);
    exp = sb.pop_front();
    checks++;
    if (!got || sample_out !== exp) begin
      failures++;
      $display("FAIL overrun_inflight got=%h valid_seen=%b exp=%h", sample_out, got, exp);
    end
    exp_wr_ptr = exp_wr_ptr + 12'd2;
    extra = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (sample_out_valid) extra++;
    end
    checks++;
    if (extra != 0 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_drop got extra=%0d ovr=%b exp extra=0 ovr=1", extra, overrun);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit got; logic [DW-1:0] exp; logic [127:0] all_out;
    fx_enable = 4'b0100;
    m_auto[2] = 1'b0;
    send(16'h2222);
    wait_turn(20, got);
    fx_sram_offset[2*AW +: AW] = 12'd0;
    fx_sram_rd[2] = 1'b1;
    tick();
    fx_sram_rd = '0;
    checks++;
    if (ram_rd !== 1'b1) begin
      failures++;
      $display("FAIL mid_rd_pre got=%b exp=1", ram_rd);
    end
    rst = 1'b1;
    tick();
    all_out = 128'({sample_out, sample_out_valid, fx_cs, fx_my_turn, fx_should_save,
                    fx_data_in, fx_read_finish, fx_write_finish, ram_rd, ram_wr,
                    ram_addr, ram_wdata, overrun, timeout_err});
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%h exp=0", all_out);
    end
    rst = 1'b0;
    exp_wr_ptr = '0;
    m_auto = '1;
    fx_enable = 4'b0010;
    m_add = 16'd1;
    sb.push_back(16'h0100);
    send(16'h00FF);
    collect(30, cyc, got);
    exp = sb.pop_front();
    checks++;
    if (!got || sample_out !== exp) begin
      failures++;
      $display("FAIL post_reset_out got=%h valid_seen=%b exp=%h", sample_out, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    sample_valid = 1'b0;
    sample_in = '0;
    fx_enable = '0;
    freeze = 1'b0;
    fx_data_out = '0;
    fx_done = '0;
    fx_available = '1;
    fx_sram_rd = '0;
    fx_sram_wr = '0;
    fx_sram_offset = '0;
    fx_sram_data = '0;
    ram_read_finish = 1'b0;
    ram_write_finish = 1'b0;
    m_auto = '1;
    m_delay = 3;
    m_add = 16'd1;
    exp_wr_ptr = '0;
    for (int i = 0; i < NFX; i++) m_cnt[i] = 0;

    test_reset();
    test_all_disabled();
    test_ram_arb();
    test_slot1();
    test_timeout();
    test_overrun();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
